alu_seq: RTL and testbench

//   Parametrised, registered, handshaked successor to the 32-bit combinational datapath ALU.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_mul.sv | 60 ++++++
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encoding and flag bit order shared by
// alu_seq and its iterative multiplier alu_seq_mul.
package alu_seq_pkg;

  // Opcodes carried on the 4-bit command input; 12-15 are always illegal.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  // Handshake FSM: IDLE waits for work, BUSY runs the multiplier, DONE presents a result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } stateT;

  // Bit positions of the registered flag vector.
  localparam int FLAG_CARRY   = 0;
  localparam int FLAG_OVF     = 1;
  localparam int FLAG_ZERO    = 2;
  localparam int FLAG_ILLEGAL = 3;
  localparam int FLAG_W       = 4;

  // SUB and SLT both run A + ~B + 1 through the adder.
  function automatic logic usesSubtract(input logic [3:0] cmd);
    return (cmd == OP_SUB) || (cmd == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: shift-add multiplier returning the low WIDTH bits of the
// unsigned product. start loads the operands; WIDTH steps follow, one per
// cycle. done is high during the cycle of the final step and product then
// already carries the finished value, so the caller captures it on that edge.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] accReg;
  logic [WIDTH-1:0] mcandReg;
  logic [WIDTH-1:0] mplierReg;
  logic [CNT_W-1:0] countReg;
  logic             busyReg;

  // Partial sum after this cycle's step; doubles as the final product on the last step.
  always_comb begin
    product = accReg + (mplierReg[0] ? mcandReg : '0);
    done    = busyReg && (countReg == CNT_W'(WIDTH - 1));
    busy    = busyReg;
  end

  // Operand load on start, then one add-and-shift per cycle until the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accReg    <= '0;
      mcandReg  <= '0;
      mplierReg <= '0;
      countReg  <= '0;
      busyReg   <= 1'b0;
    end else if (start) begin
      accReg    <= '0;
      mcandReg  <= multiplicand;
      mplierReg <= multiplier;
      countReg  <= '0;
      busyReg   <= 1'b1;
    end else if (busyReg) begin
      accReg    <= product;
      mcandReg  <= mcandReg << 1;
      mplierReg <= mplierReg >> 1;
      countReg  <= countReg + CNT_W'(1);
      if (done) begin
        busyReg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready handshaked ALU. Single-cycle ops return
// their result one cycle after accept; a result is held until out_ready.
// Build option ALU_SEQ_MUL_EN: when defined, opcode 11 is an iterative
// WIDTH-cycle multiply; when undefined, opcode 11 is illegal and every op
// has latency 1.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       command,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  stateT             stateReg;
  logic [WIDTH-1:0]  resultReg;
  logic [FLAG_W-1:0] flagsReg;

  logic              accept;
  logic              cmdIsMul;
  logic              mulDone;
  logic [WIDTH-1:0]  mulProduct;

  logic [WIDTH-1:0]  bOperand;
  logic              carryIn;
  logic [WIDTH:0]    fullSum;
  logic              carryMsb;
  logic              carryIntoMsb;
  logic              sumOvf;
  logic [SHW-1:0]    shamt;
  logic [WIDTH-1:0]  andBits;
  logic [WIDTH-1:0]  orBits;
  logic [WIDTH-1:0]  xorBits;
  logic [WIDTH-1:0]  aluResult;
  logic [FLAG_W-1:0] aluFlags;

  // Per-bit logic functions; NAND and NOR reuse these inverted.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : gLogic
    assign andBits[gi] = operandA[gi] & operandB[gi];
    assign orBits[gi]  = operandA[gi] | operandB[gi];
    assign xorBits[gi] = operandA[gi] ^ operandB[gi];
  end

  // Shared adder; carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    carryIn      = usesSubtract(command);
    bOperand     = carryIn ? ~operandB : operandB;
    fullSum      = {1'b0, operandA} + {1'b0, bOperand} + (WIDTH + 1)'(carryIn);
    carryMsb     = fullSum[WIDTH];
    carryIntoMsb = fullSum[WIDTH-1] ^ operandA[WIDTH-1] ^ bOperand[WIDTH-1];
    sumOvf       = carryMsb ^ carryIntoMsb;
    shamt        = operandB[SHW-1:0];
  end

  // Single-cycle result and flags; anything unsupported yields result 0, illegal 1.
  always_comb begin
    aluResult = '0;
    aluFlags  = '0;
    case (command)
      OP_ADD, OP_SUB: begin
        aluResult            = fullSum[WIDTH-1:0];
        aluFlags[FLAG_CARRY] = carryMsb;
        aluFlags[FLAG_OVF]   = sumOvf;
      end
      OP_SLT: begin
        aluResult            = WIDTH'(fullSum[WIDTH-1] ^ sumOvf);
        aluFlags[FLAG_CARRY] = carryMsb;
        aluFlags[FLAG_OVF]   = sumOvf;
      end
      OP_XOR:  aluResult = xorBits;
      OP_AND:  aluResult = andBits;
      OP_NAND: aluResult = ~andBits;
      OP_NOR:  aluResult = ~orBits;
      OP_OR:   aluResult = orBits;
      OP_SLL:  aluResult = operandA << shamt;
      OP_SRL:  aluResult = operandA >> shamt;
      OP_SRA:  aluResult = WIDTH'($signed(operandA) >>> shamt);
      // With the multiplier built in, opcode 11 is routed to BUSY and this value is never captured.
      OP_MUL:  aluFlags[FLAG_ILLEGAL] = 1'b1;
      default: aluFlags[FLAG_ILLEGAL] = 1'b1;
    endcase
    aluFlags[FLAG_ZERO] = (aluResult == '0);
  end

`ifdef ALU_SEQ_MUL_EN
  logic mulBusy;

  assign cmdIsMul = (command == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) uMul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (accept && cmdIsMul),
    .multiplicand (operandA),
    .multiplier   (operandB),
    .busy         (mulBusy),
    .done         (mulDone),
    .product      (mulProduct)
  );
`else
  assign cmdIsMul   = 1'b0;
  assign mulDone    = 1'b0;
  assign mulProduct = '0;
`endif

  // Handshake: a DONE result leaving this cycle frees the slot for a chained accept.
  always_comb begin
    in_ready  = (stateReg == ST_IDLE) || ((stateReg == ST_DONE) && out_ready);
    out_valid = (stateReg == ST_DONE);
    accept    = in_valid && in_ready;
    result    = resultReg;
    carryout  = flagsReg[FLAG_CARRY];
    overflow  = flagsReg[FLAG_OVF];
    zero      = flagsReg[FLAG_ZERO];
    illegal   = flagsReg[FLAG_ILLEGAL];
  end

  // FSM and output registers; result/flags only change when a new one is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= ST_IDLE;
      resultReg <= '0;
      flagsReg  <= '0;
    end else if (accept) begin
      if (cmdIsMul) begin
        stateReg <= ST_BUSY;
      end else begin
        stateReg  <= ST_DONE;
        resultReg <= aluResult;
        flagsReg  <= aluFlags;
      end
    end else if ((stateReg == ST_DONE) && out_ready) begin
      stateReg <= ST_IDLE;
    end else if ((stateReg == ST_BUSY) && mulDone) begin
      stateReg            <= ST_DONE;
      resultReg           <= mulProduct;
      flagsReg            <= '0;
      flagsReg[FLAG_ZERO] <= (mulProduct == '0);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, table-driven bench for alu_seq at WIDTH=32, plus
// hand-written sequences for hold, back-to-back, multiply and reset abort.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   command;
  logic [W-1:0] operandA;
  logic [W-1:0] operandB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         zero;
  logic         illegal;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic [3:0]   cmd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         i;
  } vecT;

  vecT vecs[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .command   (command),
    .operandA  (operandA),
    .operandB  (operandB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryout  (carryout),
    .overflow  (overflow),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vecT mk(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] r, input logic cf, input logic vf,
                             input logic zf, input logic iflag);
    vecT v;
    v.cmd = c; v.a = a; v.b = b; v.res = r;
    v.c = cf; v.v = vf; v.z = zf; v.i = iflag;
    return v;
  endfunction

  function automatic logic [63:0] packOut();
    return {28'd0, result, carryout, overflow, zero, illegal};
  endfunction

  function automatic logic [63:0] packExp(input vecT v);
    return {28'd0, v.res, v.c, v.v, v.z, v.i};
  endfunction

  // One transaction: accept, check latency-1 result with scrambled inputs, then retire it.
  task automatic applyVec(input vecT v);
    @(negedge clk);
    in_valid  = 1'b1;
    command   = v.cmd;
    operandA  = v.a;
    operandB  = v.b;
    out_ready = 1'b0;
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    command  = 4'($urandom);
    operandA = $urandom;
    operandB = $urandom;
    check("out_valid_latency1", 64'(out_valid), 64'd1);
    check("result_flags", packOut(), packExp(v));
    $display("[TB] op=%0d a=%h b=%h -> result=%h c=%b v=%b z=%b i=%b",
             v.cmd, v.a, v.b, result, carryout, overflow, zero, illegal);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drops", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [W-1:0] held;
    logic         seen;
    logic [W-1:0] expRes;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    command   = 4'd0;
    operandA  = '0;
    operandB  = '0;
    #1 rst_n = 1'b0;
    #11;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", packOut(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(mk(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(OP_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SLT,  32'h0000_0001, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(OP_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SRL,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SRA,  32'h7FFF_FFFF, 32'h0000_0004, 32'h07FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SLL,  32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd15,   32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(4'd12,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_ADD,  32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0));
`ifndef ALU_SEQ_MUL_EN
    vecs.push_back(mk(OP_MUL,  32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1));
`endif

    foreach (vecs[k]) begin
      applyVec(vecs[k]);
    end

    // Hold: result stays put for 3 cycles of out_ready=0 while the inputs keep changing.
    @(negedge clk);
    in_valid = 1'b1; command = OP_XOR; operandA = 32'hDEAD_BEEF; operandB = 32'h0F0F_0F0F;
    @(posedge clk);
    #1;
    command = OP_ADD; operandA = 32'h1; operandB = 32'h1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(result), 64'hD1A2_B1E0);
    end
    $display("[TB] hold xor result=%h for 3 cycles", result);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Back-to-back XOR/AND stream with out_ready held: one result per cycle.
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      command  = (i % 2 == 1) ? OP_AND : OP_XOR;
      operandA = 32'h1357_9BDF + 32'(i) * 32'h0101_0101;
      operandB = 32'hF0F0_3C3C ^ (32'(i) << 8);
      expRes   = (i % 2 == 1) ? (operandA & operandB) : (operandA ^ operandB);
      check("b2b_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      check("b2b_out_valid", 64'(out_valid), 64'd1);
      check("b2b_result", 64'(result), 64'(expRes));
      $display("[TB] b2b #%0d op=%0d result=%h", i, command, result);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_no_duplicate", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

`ifdef ALU_SEQ_MUL_EN
    // Multiply: busy for 32 cycles, inputs ignored meanwhile, then a held result.
    @(negedge clk);
    in_valid = 1'b1; command = OP_MUL; operandA = 32'h0000_FFFF; operandB = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    command = OP_ADD; operandA = 32'h5; operandB = 32'h6;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      check("mul_busy", {62'd0, out_valid, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mul_latency", 64'(out_valid), 64'd1);
    held = result;
    check("mul_result_flags", packOut(), {28'd0, 32'hFFFE_0001, 4'b0000});
    $display("[TB] mul ffff*ffff result=%h", result);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("mul_hold", {31'd0, out_valid, result}, {31'd0, 1'b1, held});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset in cycle 10 of a multiply aborts it.
    @(negedge clk);
    in_valid = 1'b1; command = OP_MUL; operandA = 32'h0000_0003; operandB = 32'h0000_0007;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("pre_reset_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("reset_abort_valid", 64'(out_valid), 64'd0);
    check("reset_abort_ready", 64'(in_ready), 64'd1);
`else
    // Reset while a result is waiting drops it at once.
    @(negedge clk);
    in_valid = 1'b1; command = OP_ADD; operandA = 32'h1; operandB = 32'h1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_abort_valid", 64'(out_valid), 64'd0);
    check("reset_abort_result", 64'(result), 64'd0);
`endif
    $display("[TB] reset asserted mid-operation");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("no_output_after_abort", 64'(seen), 64'd0);
    applyVec(mk(OP_ADD, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
